// File: rtl/rw_burst_scheduler.sv
// rw_burst_scheduler: queues up to DEPTH read/write CAS commands, each with its
// own countdown, and drives the data-phase strobes when a head command is due.
// Optional build macro: RW_TURNAROUND_EN inserts two idle cycles between
// bursts of opposite direction.
module rw_burst_scheduler #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 6,
  parameter int unsigned BL    = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    clock_t,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        rd_delay,
  input  logic [CNT_W-1:0]        wr_delay,
  input  logic                    cmd_valid,
  input  logic                    cmd_rw,
  input  logic [TAG_W-1:0]        cmd_tag,
  output logic                    cmd_ready,
  output logic                    data_start,
  output logic                    data_active,
  output logic                    data_last,
  output logic                    data_rw,
  output logic [TAG_W-1:0]        data_tag,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    rw_idle,
  output logic                    overflow,
  output logic                    late
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned OCC_W    = PTR_W + 1;
  localparam int unsigned HALF     = BL / 2;
  localparam int unsigned BC_W     = $clog2(HALF);
  localparam int unsigned GAP_W    = 2;
  localparam int unsigned TURN_GAP = 2;
`ifdef RW_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_t;

  state_t             state_q, state_d;
  logic [BC_W-1:0]    bcnt_q, bcnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               vld_q  [DEPTH];
  logic               frw_q  [DEPTH];
  logic [TAG_W-1:0]   ftag_q [DEPTH];
  logic [CNT_W-1:0]   rem_q  [DEPTH];

  logic               cmd_ready_q, start_q, active_q, last_q, drw_q, idle_q, ovf_q, late_q;
  logic [TAG_W-1:0]   dtag_q;

  logic               accept, pop, start_d, drw_d, late_set, burst_end;
  logic               head_vld, head_rw, head_zero, turn_block, head_due;
  logic [TAG_W-1:0]   head_tag, dtag_d;
  logic [CNT_W-1:0]   dly, dly_m1;

  assign accept    = cmd_valid && cmd_ready_q;
  assign dly       = cmd_rw ? rd_delay : wr_delay;
  assign dly_m1    = (dly == '0) ? '0 : dly - CNT_W'(1);
  assign head_vld  = (occ_q != '0);
  assign head_rw   = frw_q[rd_ptr_q];
  assign head_tag  = ftag_q[rd_ptr_q];
  assign head_zero = head_vld && (rem_q[rd_ptr_q] == '0);
  assign burst_end = (state_q == ST_DATA) && (bcnt_q == BC_W'(HALF - 1));
  // Opposite-direction head must wait out the current burst plus the gap.
  assign turn_block = TURN_EN && head_vld && (head_rw != drw_q) &&
                      ((state_q == ST_DATA) || (gap_q != '0));
  assign head_due  = head_zero && !turn_block;
  assign occ_d     = occ_q + OCC_W'(accept) - OCC_W'(pop);

  // Next-state, pop decision and strobe values for the following cycle.
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    pop      = 1'b0;
    start_d  = 1'b0;
    drw_d    = drw_q;
    dtag_d   = dtag_q;
    late_set = 1'b0;
    gap_d    = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
    if (burst_end) gap_d = GAP_W'(TURN_GAP - 1);
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (head_due) begin
          pop     = 1'b1;
          start_d = 1'b1;
          drw_d   = head_rw;
          dtag_d  = head_tag;
          bcnt_d  = '0;
          state_d = ST_DATA;
        end else if (head_zero) begin
          late_set = 1'b1;
        end
      end
      ST_DATA: begin
        if (burst_end) begin
          if (head_due) begin
            pop     = 1'b1;
            start_d = 1'b1;
            drw_d   = head_rw;
            dtag_d  = head_tag;
            bcnt_d  = '0;
          end else if (head_vld || accept) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + BC_W'(1);
          if (head_zero) late_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, strobe and status registers.
  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bcnt_q      <= '0;
      gap_q       <= '0;
      occ_q       <= '0;
      cmd_ready_q <= 1'b1;
      start_q     <= 1'b0;
      active_q    <= 1'b0;
      last_q      <= 1'b0;
      drw_q       <= 1'b0;
      dtag_q      <= '0;
      idle_q      <= 1'b1;
      ovf_q       <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      gap_q       <= gap_d;
      occ_q       <= occ_d;
      cmd_ready_q <= (occ_d < OCC_W'(DEPTH));
      start_q     <= start_d;
      active_q    <= (state_d == ST_DATA);
      last_q      <= (state_d == ST_DATA) && (bcnt_d == BC_W'(HALF - 1));
      drw_q       <= drw_d;
      dtag_q      <= dtag_d;
      idle_q      <= (occ_d == '0) && (state_d != ST_DATA);
      if (cmd_valid && !cmd_ready_q) ovf_q <= 1'b1;
      if (late_set) late_q <= 1'b1;
    end
  end

  // Command FIFO with per-entry saturating countdowns.
  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        vld_q[i]  <= 1'b0;
        frw_q[i]  <= 1'b0;
        ftag_q[i] <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (vld_q[i] && (rem_q[i] != '0)) rem_q[i] <= rem_q[i] - CNT_W'(1);
      end
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
      end
      if (accept) begin
        vld_q[wr_ptr_q]  <= 1'b1;
        frw_q[wr_ptr_q]  <= cmd_rw;
        ftag_q[wr_ptr_q] <= cmd_tag;
        rem_q[wr_ptr_q]  <= dly_m1;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign data_start  = start_q;
  assign data_active = active_q;
  assign data_last   = last_q;
  assign data_rw     = drw_q;
  assign data_tag    = dtag_q;
  assign occupancy   = occ_q;
  assign rw_idle     = idle_q;
  assign overflow    = ovf_q;
  assign late        = late_q;

endmodule
